alu_mc_unit: RTL and testbench



---
 rtl/alu_mc_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_mc_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle ops are registered straight into HOLD on accept. DIV/MOD with a
// nonzero divisor run a restoring divider that produces one quotient bit per
// clock.

package alu_mc_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_EQL, OP_GT,
        OP_LT,  OP_AND, OP_OR,  OP_XOR, OP_NOT, OP_SL,  OP_SR,  OP_SRA
    } alu_operator_t;
endpackage

// state  | meaning
// S_IDLE | ready for a new request, ready_o=1
// S_DIV  | restoring divide in progress, one quotient bit per cycle
// S_HOLD | result presented on valid_o until ready_i
module alu_mc_unit
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  alu_operator_t    oper_i,
    input  logic [WIDTH-1:0] a_data_i,
    input  logic [WIDTH-1:0] b_data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             div0_o
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_HOLD} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             is_mod;

    logic [WIDTH-1:0]   sc_result;
    logic               sc_carry;
    logic               is_div_op;
    logic               b_zero;
    logic               big_shift;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quot_nx;
    logic [WIDTH-1:0]   div_result;

    assign is_div_op = (oper_i == OP_DIV) || (oper_i == OP_MOD);
    assign b_zero    = (b_data_i == '0);
    // Any set bit above the shift-amount field means the shift is >= WIDTH.
    assign big_shift = |b_data_i[WIDTH-1:SHW];
    assign shamt     = b_data_i[SHW-1:0];
    assign sum       = {1'b0, a_data_i} + {1'b0, b_data_i};
    assign prod      = (2*WIDTH)'(a_data_i) * (2*WIDTH)'(b_data_i);

    // Single-cycle result and carry, computed from the operands presented at accept
    always_comb begin
        sc_result = '0;
        sc_carry  = 1'b0;
        case (oper_i)
            OP_NOP: sc_result = '0;
            OP_ADD: begin
                sc_result = sum[WIDTH-1:0];
                sc_carry  = sum[WIDTH];
            end
            OP_SUB: begin
                sc_result = a_data_i - b_data_i;
                sc_carry  = (a_data_i < b_data_i);
            end
            OP_MUL: begin
                sc_result = prod[WIDTH-1:0];
                sc_carry  = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: sc_result = '1;
            OP_MOD: sc_result = a_data_i;
            OP_EQL: sc_result = WIDTH'(a_data_i == b_data_i);
            OP_GT:  sc_result = WIDTH'(a_data_i > b_data_i);
            OP_LT:  sc_result = WIDTH'(a_data_i < b_data_i);
            OP_AND: sc_result = a_data_i & b_data_i;
            OP_OR:  sc_result = a_data_i | b_data_i;
            OP_XOR: sc_result = a_data_i ^ b_data_i;
            OP_NOT: sc_result = ~a_data_i;
            OP_SL:  sc_result = big_shift ? '0 : (a_data_i << shamt);
            OP_SR:  sc_result = big_shift ? '0 : (a_data_i >> shamt);
            OP_SRA: sc_result = big_shift ? {WIDTH{a_data_i[WIDTH-1]}}
                                          : WIDTH'($signed(a_data_i) >>> shamt);
            default: sc_result = '0;
        endcase
    end

    // One restoring-divide step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        rem_sh     = {rem, quot[WIDTH-1]};
        ge         = (rem_sh >= {1'b0, dvsr});
        diff       = rem_sh[WIDTH-1:0] - dvsr;
        rem_nx     = ge ? diff : rem_sh[WIDTH-1:0];
        quot_nx    = {quot[WIDTH-2:0], ge};
        div_result = is_mod ? rem_nx : quot_nx;
    end

    // Control FSM with registered handshake, result and flag outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            data_o  <= '0;
            zero_o  <= 1'b0;
            carry_o <= 1'b0;
            div0_o  <= 1'b0;
            cnt     <= '0;
            dvsr    <= '0;
            quot    <= '0;
            rem     <= '0;
            is_mod  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        ready_o <= 1'b0;
                        if (is_div_op && !b_zero) begin
                            dvsr   <= b_data_i;
                            quot   <= a_data_i;
                            rem    <= '0;
                            cnt    <= '0;
                            is_mod <= (oper_i == OP_MOD);
                            state  <= S_DIV;
                        end else begin
                            data_o  <= sc_result;
                            zero_o  <= (sc_result == '0);
                            carry_o <= sc_carry;
                            div0_o  <= is_div_op;
                            valid_o <= 1'b1;
                            state   <= S_HOLD;
                        end
                    end
                end
                S_DIV: begin
                    rem  <= rem_nx;
                    quot <= quot_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH-1)) begin
                        data_o  <= div_result;
                        zero_o  <= (div_result == '0);
                        carry_o <= 1'b0;
                        div0_o  <= 1'b0;
                        valid_o <= 1'b1;
                        state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        cnt     <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc_unit.sv
// Bench for alu_mc_unit: directed vectors against a queue-based reference model
// of the operation semantics, plus hand-computed literal expectations.
module tb_alu_mc_unit;
    import alu_mc_pkg::*;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    alu_operator_t oper_i;
    logic [31:0]   a_data_i;
    logic [31:0]   b_data_i;
    logic          valid_o;
    logic          ready_i;
    logic [31:0]   data_o;
    logic          zero_o;
    logic          carry_o;
    logic          div0_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        carry;
        logic        div0;
    } exp_t;

    exp_t exp_q[$];

    alu_mc_unit #(.WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .oper_i   (oper_i),
        .a_data_i (a_data_i),
        .b_data_i (b_data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .zero_o   (zero_o),
        .carry_o  (carry_o),
        .div0_o   (div0_o)
    );

    always #5 clk = ~clk;

    // Reference semantics in plain arithmetic
    function automatic exp_t model(input alu_operator_t op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        e = '0;
        p = 64'(a) * 64'(b);
        case (op)
            OP_ADD: begin e.data = a + b; e.carry = ((64'(a) + 64'(b)) >> 32) != 0; end
            OP_SUB: begin e.data = a - b; e.carry = (a < b); end
            OP_MUL: begin e.data = p[31:0]; e.carry = (p >> 32) != 0; end
            OP_DIV: begin
                if (b == 0) begin e.data = 32'hFFFF_FFFF; e.div0 = 1'b1; end
                else e.data = a / b;
            end
            OP_MOD: begin
                if (b == 0) begin e.data = a; e.div0 = 1'b1; end
                else e.data = a % b;
            end
            OP_EQL: e.data = (a == b) ? 32'd1 : 32'd0;
            OP_GT:  e.data = (a > b) ? 32'd1 : 32'd0;
            OP_LT:  e.data = (a < b) ? 32'd1 : 32'd0;
            OP_AND: e.data = a & b;
            OP_OR:  e.data = a | b;
            OP_XOR: e.data = a ^ b;
            OP_NOT: e.data = ~a;
            OP_SL:  e.data = a << b;
            OP_SR:  e.data = a >> b;
            OP_SRA: e.data = $signed(a) >>> b;
            default: e.data = 32'd0;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, advance the model, compare at negedge
    task automatic tick();
        logic          acc, cons, rs;
        alu_operator_t op;
        logic [31:0]   a, b;
        exp_t          e;
        acc  = (valid_i === 1'b1) && (ready_o === 1'b1);
        cons = (valid_o === 1'b1) && (ready_i === 1'b1);
        rs   = rst_i;
        op   = oper_i;
        a    = a_data_i;
        b    = b_data_i;
        @(posedge clk);
        if (rs) exp_q.delete();
        else begin
            if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(model(op, a, b));
        end
        @(negedge clk);
        chk("ready_vs_model", ready_o, (exp_q.size() == 0));
        if (valid_o !== 1'b0) begin
            chk("valid_has_pending", valid_o && (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("data", data_o, e.data);
                chk("zero", zero_o, (e.data == 0));
                chk("carry", carry_o, e.carry);
                chk("div0", div0_o, e.div0);
            end
        end
    endtask

    // Issue one request and wait (bounded) for valid_o; lat=1 means valid right after accept
    task automatic run_op(input alu_operator_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic rdy, output int lat);
        oper_i   = op;
        a_data_i = a;
        b_data_i = b;
        valid_i  = 1'b1;
        ready_i  = rdy;
        tick();
        valid_i  = 1'b0;
        a_data_i = $urandom;
        b_data_i = $urandom;
        oper_i   = alu_operator_t'($urandom_range(0, 15));
        lat = 1;
        while (valid_o !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("valid_seen", valid_o, 1);
    endtask

    task automatic consume();
        ready_i = 1'b1;
        tick();
    endtask

    typedef struct {
        alu_operator_t op;
        logic [31:0]   a;
        logic [31:0]   b;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int   lat;
        int   seen;
        logic [31:0] held_data;
        logic held_zero, held_carry;

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        oper_i = OP_NOP; a_data_i = '0; b_data_i = '0;
        @(negedge clk);

        // Reset
        tick(); tick();
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_flags", {zero_o, carry_o, div0_o}, 0);
        rst_i = 1'b0;
        tick();

        // ADD overflow, then back-to-back accept
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, lat);
        chk("add_lat", lat, 1);
        chk("add_data", data_o, 0);
        chk("add_zero", zero_o, 1);
        chk("add_carry", carry_o, 1);
        consume();
        chk("b2b_ready", ready_o, 1);
        run_op(OP_ADD, 32'd3, 32'd4, 1'b1, lat);
        chk("add2_data", data_o, 7);
        consume();

        // Divider latency and results
        run_op(OP_DIV, 32'd100, 32'd7, 1'b1, lat);
        chk("div_lat", lat, 33);
        chk("div_data", data_o, 14);
        consume();
        run_op(OP_MOD, 32'd100, 32'd7, 1'b1, lat);
        chk("mod_lat", lat, 33);
        chk("mod_data", data_o, 2);
        consume();

        // Divide by zero
        run_op(OP_DIV, 32'd5, 32'd0, 1'b1, lat);
        chk("div0_lat", lat, 1);
        chk("div0_data", data_o, 32'hFFFF_FFFF);
        chk("div0_flag", div0_o, 1);
        consume();
        run_op(OP_MOD, 32'd5, 32'd0, 1'b1, lat);
        chk("mod0_data", data_o, 5);
        chk("mod0_flag", div0_o, 1);
        consume();

        // Oversized shifts and AND
        run_op(OP_SRA, 32'h8000_0000, 32'd40, 1'b1, lat);
        chk("sra_big", data_o, 32'hFFFF_FFFF);
        consume();
        run_op(OP_SL, 32'h8000_0000, 32'd40, 1'b1, lat);
        chk("sl_big", data_o, 0);
        consume();
        run_op(OP_AND, 32'hF0, 32'h3C, 1'b1, lat);
        chk("and_data", data_o, 32'h30);
        consume();

        // Vector table, checked against the model every cycle
        vecs = '{
            '{OP_NOP, 32'h1234_5678, 32'h9},
            '{OP_SUB, 32'd3, 32'd5},
            '{OP_SUB, 32'd9, 32'd9},
            '{OP_MUL, 32'h0001_0000, 32'h0001_0000},
            '{OP_MUL, 32'd1234, 32'd5678},
            '{OP_EQL, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
            '{OP_EQL, 32'hDEAD_BEEF, 32'hDEAD_BEEE},
            '{OP_GT,  32'h8000_0000, 32'h7FFF_FFFF},
            '{OP_LT,  32'h8000_0000, 32'h7FFF_FFFF},
            '{OP_OR,  32'hF0F0_0000, 32'h0000_0F0F},
            '{OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00},
            '{OP_NOT, 32'h0F0F_0F0F, 32'h0},
            '{OP_SR,  32'h8000_0000, 32'd31},
            '{OP_SRA, 32'h8000_0010, 32'd4},
            '{OP_SL,  32'h0000_0003, 32'd31},
            '{OP_SR,  32'hFFFF_FFFF, 32'd32},
            '{OP_DIV, 32'hFFFF_FFFF, 32'd1},
            '{OP_DIV, 32'd3, 32'd10},
            '{OP_MOD, 32'hDEAD_BEEF, 32'h0001_2345},
            '{OP_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF}
        };
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, lat);
            chk("vec_lat", lat,
                ((vecs[i].op == OP_DIV || vecs[i].op == OP_MOD) && vecs[i].b != 0) ? 33 : 1);
            consume();
        end

        // Backpressure in HOLD
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, lat);
        held_data = data_o; held_zero = zero_o; held_carry = carry_o;
        chk("bp_data", held_data, 0);
        chk("bp_carry", held_carry, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", data_o, held_data);
            chk("bp_hold_flags", {zero_o, carry_o}, {held_zero, held_carry});
            chk("bp_ready", ready_o, 0);
            chk("bp_valid", valid_o, 1);
        end
        consume();

        // Reset in the middle of a divide
        oper_i = OP_DIV; a_data_i = 32'd1000; b_data_i = 32'd3;
        valid_i = 1'b1; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_div_busy", ready_o, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_ready", ready_o, 1);
        chk("abort_valid", valid_o, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o !== 1'b0) seen++;
        end
        chk("abort_no_result", seen, 0);

        // Unit still works after the abort
        run_op(OP_MOD, 32'd1000, 32'd3, 1'b1, lat);
        chk("post_abort_mod", data_o, 1);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
